decode_execute_reg: RTL and testbench
=====================================

Name: decode_execute_reg

Overview:
- ID/EX pipeline register between the decode stage (control unit, register file, sign extender) and the execute stage.
- Captures decoded control signals, operands and register specifiers each cycle.
- Detects load-use hazards against the instruction currently in execute and inserts a one-cycle bubble.
- Honours a branch/jump flush and an execute-side hold.

Parameters:
DATA_W, 32, operand/immediate width
REG_ADDR_W, 5, register specifier width
PC_W, 32, program counter width
LINK_REG, 31, destination register for reg_dst=2'b10 (JAL)

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  synchronous active-low reset
valid_d  in  1  decode slot holds a real instruction
reg_write_d  in  1  control from decode
mem_to_reg_d  in  2  00 ALU, 01 memory, 10 PC+4
mem_write_d  in  1  control from decode
alu_control_d  in  2  ALU op class
alu_src_d  in  1  0 register, 1 immediate
reg_dst_d  in  2  00 rt, 01 rd, 10 LINK_REG
jump_d  in  1  control from decode
branch_d  in  1  control from decode
rd1_d  in  DATA_W  rs operand
rd2_d  in  DATA_W  rt operand
sign_imm_d  in  DATA_W  extended immediate
pc_plus4_d  in  PC_W  link address
rs_d, rt_d, rd_d  in  REG_ADDR_W each  register specifiers
flush_e  in  1  squash decode slot (taken branch/jump)
hold_e  in  1  execute stalled; keep register contents
stall_d  out  1  decode/fetch must hold their current contents
valid_e  out  1  execute slot valid
reg_write_e, mem_to_reg_e, mem_write_e, alu_control_e, alu_src_e, jump_e, branch_e  out  widths as _d  registered controls
rd1_e, rd2_e, sign_imm_e, pc_plus4_e, rs_e, rt_e  out  widths as _d  registered data
write_reg_e  out  REG_ADDR_W  resolved destination register
bubble_count  out  32  inserted-bubble count (see Optional Feature)

Behaviour:
- Reset:
  - When rst_n=0 at a clock edge, all _e outputs, valid_e and write_reg_e are cleared to 0 next cycle.
  - bubble_count is cleared to 0.
  - Reset overrides every other input.
- Load-use hazard (combinational):
  - load_use = valid_e & reg_write_e & (mem_to_reg_e==2'b01) & (write_reg_e!=0) & valid_d & ((write_reg_e==rs_d) | (write_reg_e==rt_d)).
- stall_d = hold_e | (load_use & ~flush_e). stall_d is purely combinational; it has no reset flop.
- Destination resolution at capture: write_reg_e <= rt_d, rd_d or LINK_REG for reg_dst_d 00, 01 or 10. Encoding 11 maps to 0.
- Update priority at each edge:
  1. reset
  2. hold_e: all registers keep their value, including valid_e and bubble_count.
  3. flush_e: insert bubble.
  4. load_use: insert bubble.
  5. Otherwise load all _d values. valid_e <= valid_d. If valid_d=0, all control outputs load as 0.
- Bubble: valid_e=0 and reg_write_e, mem_write_e, branch_e, jump_e = 0. Other fields go to 0 as well.
- Latency: one cycle from _d to _e.
- Load-use stall lasts exactly one cycle, because the bubble clears the hazard condition.
- hold_e together with flush_e: hold wins, and the flush is not remembered. The upstream hazard unit must keep flush_e asserted until hold_e drops.
- A bubble with write_reg_e=0 never triggers load_use (register 0 is excluded).

Optional Feature:
- Macro: DECODE_EXECUTE_PERF_EN.
- Defined:
  - bubble_count is a 32-bit counter that increments on every edge where a bubble is inserted (flush or load_use, not hold, not reset).
  - It wraps from 0xFFFFFFFF to 0.
- Undefined: bubble_count is tied to 0 and no counter flops exist.

Test Plan:
- Reset: drive rst_n=0 with all _d inputs = all-ones for 2 cycles -> every _e output, valid_e and write_reg_e = 0. Release reset -> next edge captures the inputs.
- Pass-through: ADDI-like inputs (reg_write_d=1, alu_src_d=1, reg_dst_d=00, rt_d=9, sign_imm_d=0x0000_0010) -> next cycle reg_write_e=1, write_reg_e=9, sign_imm_e=0x10, valid_e=1, stall_d=0.
- Load-use: cycle N captures LW with rt_d=8. Cycle N+1 decode has rs_d=8 -> stall_d=1 in N+1. At N+2 valid_e=0 and reg_write_e=0. Holding decode inputs, stall_d=0 in N+2 and the dependent instruction is captured at N+3. bubble_count=1 when DECODE_EXECUTE_PERF_EN is defined.
- Load to $0: LW with rt_d=0 followed by a consumer with rs_d=0 -> stall_d stays 0 and no bubble is inserted.
- Flush vs hold: flush_e=1 with valid_d=1 -> next valid_e=0 and mem_write_e=0. Then hold_e=1 and flush_e=1 for 3 cycles -> all _e outputs unchanged, stall_d=1 and bubble_count unchanged.
- JAL destination: reg_dst_d=10, mem_to_reg_d=10, pc_plus4_d=0x0040_0008 -> write_reg_e=31 and pc_plus4_e=0x0040_0008.

Source files
------------

// File: rtl/decode_execute_reg.sv
// decode_execute_reg: ID/EX pipeline register with load-use bubble insertion,
// branch/jump flush and execute-side hold.
// Optional inserted-bubble counter enabled by defining DECODE_EXECUTE_PERF_EN.
module decode_execute_reg #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned PC_W       = 32,
    parameter int unsigned LINK_REG   = 31
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_d,
    input  logic                  reg_write_d,
    input  logic [1:0]            mem_to_reg_d,
    input  logic                  mem_write_d,
    input  logic [1:0]            alu_control_d,
    input  logic                  alu_src_d,
    input  logic [1:0]            reg_dst_d,
    input  logic                  jump_d,
    input  logic                  branch_d,
    input  logic [DATA_W-1:0]     rd1_d,
    input  logic [DATA_W-1:0]     rd2_d,
    input  logic [DATA_W-1:0]     sign_imm_d,
    input  logic [PC_W-1:0]       pc_plus4_d,
    input  logic [REG_ADDR_W-1:0] rs_d,
    input  logic [REG_ADDR_W-1:0] rt_d,
    input  logic [REG_ADDR_W-1:0] rd_d,
    input  logic                  flush_e,
    input  logic                  hold_e,
    output logic                  stall_d,
    output logic                  valid_e,
    output logic                  reg_write_e,
    output logic [1:0]            mem_to_reg_e,
    output logic                  mem_write_e,
    output logic [1:0]            alu_control_e,
    output logic                  alu_src_e,
    output logic                  jump_e,
    output logic                  branch_e,
    output logic [DATA_W-1:0]     rd1_e,
    output logic [DATA_W-1:0]     rd2_e,
    output logic [DATA_W-1:0]     sign_imm_e,
    output logic [PC_W-1:0]       pc_plus4_e,
    output logic [REG_ADDR_W-1:0] rs_e,
    output logic [REG_ADDR_W-1:0] rt_e,
    output logic [REG_ADDR_W-1:0] write_reg_e,
    output logic [31:0]           bubble_count
);

    localparam logic [1:0] MTR_MEM = 2'b01;

    logic                  w_load_use;
    logic [REG_ADDR_W-1:0] w_write_reg;

    // Load in execute whose destination is read by the instruction in decode
    assign w_load_use = valid_e & reg_write_e & (mem_to_reg_e == MTR_MEM)
                      & (write_reg_e != '0) & valid_d
                      & ((write_reg_e == rs_d) | (write_reg_e == rt_d));

    // A flush squashes the consumer anyway, so it does not need to wait
    assign stall_d = hold_e | (w_load_use & ~flush_e);

    // Resolve destination register from reg_dst encoding
    always_comb begin
        w_write_reg = '0;
        case (reg_dst_d)
            2'b00:   w_write_reg = rt_d;
            2'b01:   w_write_reg = rd_d;
            2'b10:   w_write_reg = REG_ADDR_W'(LINK_REG);
            default: w_write_reg = '0;
        endcase
    end

    // Pipeline register: reset > hold > bubble (flush/load-use) > capture
    always_ff @(posedge clk) begin
        if (!rst_n || (!hold_e && (flush_e || w_load_use))) begin
            valid_e       <= 1'b0;
            reg_write_e   <= 1'b0;
            mem_to_reg_e  <= 2'b00;
            mem_write_e   <= 1'b0;
            alu_control_e <= 2'b00;
            alu_src_e     <= 1'b0;
            jump_e        <= 1'b0;
            branch_e      <= 1'b0;
            rd1_e         <= '0;
            rd2_e         <= '0;
            sign_imm_e    <= '0;
            pc_plus4_e    <= '0;
            rs_e          <= '0;
            rt_e          <= '0;
            write_reg_e   <= '0;
        end else if (!hold_e) begin
            valid_e       <= valid_d;
            reg_write_e   <= valid_d & reg_write_d;
            mem_to_reg_e  <= valid_d ? mem_to_reg_d : 2'b00;
            mem_write_e   <= valid_d & mem_write_d;
            alu_control_e <= valid_d ? alu_control_d : 2'b00;
            alu_src_e     <= valid_d & alu_src_d;
            jump_e        <= valid_d & jump_d;
            branch_e      <= valid_d & branch_d;
            rd1_e         <= rd1_d;
            rd2_e         <= rd2_d;
            sign_imm_e    <= sign_imm_d;
            pc_plus4_e    <= pc_plus4_d;
            rs_e          <= rs_d;
            rt_e          <= rt_d;
            write_reg_e   <= w_write_reg;
        end
    end

`ifdef DECODE_EXECUTE_PERF_EN
    logic        w_bubble;
    logic [31:0] r_bubble_count;

    assign w_bubble = ~hold_e & (flush_e | w_load_use);

    // Count inserted bubbles, wrapping naturally at 2^32
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bubble_count <= 32'd0;
        end else if (w_bubble) begin
            r_bubble_count <= r_bubble_count + 32'd1;
        end
    end

    assign bubble_count = r_bubble_count;
`else
    assign bubble_count = 32'd0;
`endif

endmodule

// File: tb/tb_decode_execute_reg.sv
// Testbench for decode_execute_reg: table-driven capture vectors plus
// hand-written reset, load-use, flush and hold sequences, checked through
// an expected-output scoreboard.
module tb_decode_execute_reg;

    typedef struct {
        logic        valid, rw;
        logic [1:0]  mtr;
        logic        mw;
        logic [1:0]  alu;
        logic        src;
        logic [1:0]  dst;
        logic        j, b;
        logic [31:0] rd1, rd2, imm, pc;
        logic [4:0]  rs, rt, rd;
        logic [4:0]  exp_wr;
        logic        exp_stall;
    } vec_t;

    typedef struct packed {
        logic        valid, rw;
        logic [1:0]  mtr;
        logic        mw;
        logic [1:0]  alu;
        logic        src, j, b;
        logic [31:0] rd1, rd2, imm, pc;
        logic [4:0]  rs, rt, wr;
    } out_t;

    logic clk = 1'b0;
    logic rst_n;
    logic valid_d, reg_write_d, mem_write_d, alu_src_d, jump_d, branch_d;
    logic [1:0] mem_to_reg_d, alu_control_d, reg_dst_d;
    logic [31:0] rd1_d, rd2_d, sign_imm_d, pc_plus4_d;
    logic [4:0] rs_d, rt_d, rd_d;
    logic flush_e, hold_e;
    logic stall_d, valid_e, reg_write_e, mem_write_e, alu_src_e, jump_e, branch_e;
    logic [1:0] mem_to_reg_e, alu_control_e;
    logic [31:0] rd1_e, rd2_e, sign_imm_e, pc_plus4_e, bubble_count;
    logic [4:0] rs_e, rt_e, write_reg_e;

    int   checks = 0;
    int   passed = 0;
    logic [31:0] exp_bc = 32'd0;
    out_t exp_q[$];
    out_t held;
    vec_t tbl[9];
    vec_t v;

    decode_execute_reg dut (
        .clk(clk), .rst_n(rst_n), .valid_d(valid_d), .reg_write_d(reg_write_d),
        .mem_to_reg_d(mem_to_reg_d), .mem_write_d(mem_write_d),
        .alu_control_d(alu_control_d), .alu_src_d(alu_src_d), .reg_dst_d(reg_dst_d),
        .jump_d(jump_d), .branch_d(branch_d), .rd1_d(rd1_d), .rd2_d(rd2_d),
        .sign_imm_d(sign_imm_d), .pc_plus4_d(pc_plus4_d), .rs_d(rs_d), .rt_d(rt_d),
        .rd_d(rd_d), .flush_e(flush_e), .hold_e(hold_e), .stall_d(stall_d),
        .valid_e(valid_e), .reg_write_e(reg_write_e), .mem_to_reg_e(mem_to_reg_e),
        .mem_write_e(mem_write_e), .alu_control_e(alu_control_e), .alu_src_e(alu_src_e),
        .jump_e(jump_e), .branch_e(branch_e), .rd1_e(rd1_e), .rd2_e(rd2_e),
        .sign_imm_e(sign_imm_e), .pc_plus4_e(pc_plus4_e), .rs_e(rs_e), .rt_e(rt_e),
        .write_reg_e(write_reg_e), .bubble_count(bubble_count)
    );

    always #5 clk = ~clk;

    function automatic out_t dut_out();
        out_t o;
        o = '{valid_e, reg_write_e, mem_to_reg_e, mem_write_e, alu_control_e, alu_src_e,
              jump_e, branch_e, rd1_e, rd2_e, sign_imm_e, pc_plus4_e, rs_e, rt_e, write_reg_e};
        return o;
    endfunction

    // Expected capture of a decode record: controls are dropped for an invalid slot
    function automatic out_t expect_of(input vec_t x);
        out_t o;
        o = '0;
        o.valid = x.valid;
        if (x.valid) begin
            o.rw = x.rw; o.mtr = x.mtr; o.mw = x.mw; o.alu = x.alu;
            o.src = x.src; o.j = x.j; o.b = x.b;
        end
        o.rd1 = x.rd1; o.rd2 = x.rd2; o.imm = x.imm; o.pc = x.pc;
        o.rs = x.rs; o.rt = x.rt; o.wr = x.exp_wr;
        return o;
    endfunction

    task automatic drive(input vec_t x);
        valid_d = x.valid; reg_write_d = x.rw; mem_to_reg_d = x.mtr; mem_write_d = x.mw;
        alu_control_d = x.alu; alu_src_d = x.src; reg_dst_d = x.dst; jump_d = x.j;
        branch_d = x.b; rd1_d = x.rd1; rd2_d = x.rd2; sign_imm_d = x.imm;
        pc_plus4_d = x.pc; rs_d = x.rs; rt_d = x.rt; rd_d = x.rd;
    endtask

    task automatic push_bubble();
        exp_q.push_back('0);
`ifdef DECODE_EXECUTE_PERF_EN
        exp_bc = exp_bc + 32'd1;
`endif
    endtask

    task automatic check_stall(input string name, input logic exp);
        #1;
        checks++;
        if (stall_d !== exp)
            $display("FAIL %s stall_d: got %b expected %b", name, stall_d, exp);
        else
            passed++;
    endtask

    // Advance one edge, then pop the scoreboard and compare
    task automatic tick_check(input string name);
        out_t e, a;
        @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() == 0) begin
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = exp_q.pop_front();
            a = dut_out();
            if (a !== e) $display("FAIL %s outputs: got %h expected %h", name, a, e);
            else passed++;
        end
        checks++;
        if (bubble_count !== exp_bc)
            $display("FAIL %s bubble_count: got %0d expected %0d", name, bubble_count, exp_bc);
        else
            passed++;
    endtask

    initial begin
        // order: valid rw mtr mw alu src dst j b rd1 rd2 imm pc rs rt rd exp_wr exp_stall
        tbl[0] = '{1, 1, 2'b00, 0, 2'b00, 1, 2'b00, 0, 0, 32'h11, 32'h22, 32'h0000_0010,
                   32'h100, 5'd4, 5'd9, 5'd3, 5'd9, 0};
        tbl[1] = '{1, 1, 2'b00, 0, 2'b10, 0, 2'b01, 0, 0, 32'hA5A5_A5A5, 32'h5A5A_5A5A,
                   32'hFFFF_FFF0, 32'h104, 5'd1, 5'd2, 5'd17, 5'd17, 0};
        tbl[2] = '{1, 0, 2'b00, 1, 2'b00, 1, 2'b00, 0, 0, 32'h1234, 32'h5678, 32'h8,
                   32'h108, 5'd6, 5'd5, 5'd0, 5'd5, 0};
        tbl[3] = '{1, 1, 2'b10, 0, 2'b00, 0, 2'b10, 1, 0, 32'h0, 32'h0, 32'h0010_0002,
                   32'h0040_0008, 5'd0, 5'd0, 5'd0, 5'd31, 0};
        tbl[4] = '{1, 0, 2'b00, 0, 2'b01, 0, 2'b11, 0, 1, 32'h7, 32'h7, 32'hFFFF_FFFC,
                   32'h110, 5'd7, 5'd8, 5'd9, 5'd0, 0};
        tbl[5] = '{0, 1, 2'b01, 1, 2'b11, 1, 2'b11, 1, 1, 32'hDEAD_BEEF, 32'hCAFE_F00D,
                   32'h3, 32'h114, 5'd12, 5'd12, 5'd12, 5'd0, 0};
        tbl[6] = '{1, 1, 2'b01, 0, 2'b00, 1, 2'b00, 0, 0, 32'h2000, 32'h0, 32'h4,
                   32'h118, 5'd3, 5'd12, 5'd0, 5'd12, 0};
        tbl[7] = '{1, 1, 2'b00, 0, 2'b10, 0, 2'b01, 0, 0, 32'h9, 32'hA, 32'h0,
                   32'h11C, 5'd13, 5'd14, 5'd15, 5'd15, 0};
        tbl[8] = '{1, 0, 2'b00, 0, 2'b00, 0, 2'b00, 0, 0, 32'h0, 32'h0, 32'h0,
                   32'h120, 5'd0, 5'd0, 5'd0, 5'd0, 0};

        // Reset dominates all-ones decode inputs
        rst_n = 1'b0; flush_e = 1'b0; hold_e = 1'b0;
        v = '{1, 1, 2'b11, 1, 2'b11, 1, 2'b11, 1, 1, '1, '1, '1, '1, '1, '1, '1, 5'd0, 0};
        drive(v);
        exp_q.push_back('0); tick_check("reset_cycle1");
        exp_q.push_back('0); tick_check("reset_cycle2");
        rst_n = 1'b1;
        check_stall("reset_release", 1'b0);
        exp_q.push_back(expect_of(v)); tick_check("reset_release_capture");

        // Table of single-cycle captures
        for (int i = 0; i < 9; i++) begin
            drive(tbl[i]);
            check_stall($sformatf("vec%0d", i), tbl[i].exp_stall);
            exp_q.push_back(expect_of(tbl[i]));
            tick_check($sformatf("vec%0d", i));
        end

        // Load-use: LW to $8, then consumer reading $8
        v = '{1, 1, 2'b01, 0, 2'b00, 1, 2'b00, 0, 0, 32'h40, 32'h0, 32'h8, 32'h200,
              5'd1, 5'd8, 5'd0, 5'd8, 0};
        drive(v);
        check_stall("lu_load", 1'b0);
        exp_q.push_back(expect_of(v)); tick_check("lu_load");
        v = '{1, 1, 2'b00, 0, 2'b10, 0, 2'b01, 0, 0, 32'h55, 32'h66, 32'h0, 32'h204,
              5'd8, 5'd2, 5'd10, 5'd10, 1};
        drive(v);
        check_stall("lu_stall", 1'b1);
        push_bubble(); tick_check("lu_bubble");
        check_stall("lu_after_bubble", 1'b0);
        exp_q.push_back(expect_of(v)); tick_check("lu_consumer");

        // Load to $0 never stalls
        v = '{1, 1, 2'b01, 0, 2'b00, 1, 2'b00, 0, 0, 32'h40, 32'h0, 32'h8, 32'h300,
              5'd1, 5'd0, 5'd0, 5'd0, 0};
        drive(v);
        exp_q.push_back(expect_of(v)); tick_check("r0_load");
        v = '{1, 1, 2'b00, 0, 2'b10, 0, 2'b01, 0, 0, 32'h1, 32'h2, 32'h0, 32'h304,
              5'd0, 5'd0, 5'd11, 5'd11, 0};
        drive(v);
        check_stall("r0_consumer", 1'b0);
        exp_q.push_back(expect_of(v)); tick_check("r0_consumer");

        // Flush of a valid store
        v = '{1, 0, 2'b00, 1, 2'b00, 1, 2'b00, 0, 0, 32'h77, 32'h88, 32'hC, 32'h400,
              5'd3, 5'd4, 5'd0, 5'd4, 0};
        drive(v);
        flush_e = 1'b1;
        check_stall("flush", 1'b0);
        push_bubble(); tick_check("flush_bubble");
        flush_e = 1'b0;

        // Load then consumer with concurrent flush: no stall, one bubble
        v = '{1, 1, 2'b01, 0, 2'b00, 1, 2'b00, 0, 0, 32'h40, 32'h0, 32'h8, 32'h500,
              5'd1, 5'd8, 5'd0, 5'd8, 0};
        drive(v);
        exp_q.push_back(expect_of(v)); tick_check("lu_flush_load");
        v.rs = 5'd8; v.rt = 5'd9; v.mtr = 2'b00; v.pc = 32'h504;
        drive(v);
        flush_e = 1'b1;
        check_stall("lu_flush", 1'b0);
        push_bubble(); tick_check("lu_flush_bubble");
        flush_e = 1'b0;

        // Capture a JAL, then hold+flush for 3 cycles with changing inputs
        v = tbl[3];
        drive(v);
        held = expect_of(v);
        exp_q.push_back(held); tick_check("pre_hold");
        hold_e = 1'b1; flush_e = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(tbl[k]);
            check_stall($sformatf("hold%0d", k), 1'b1);
            exp_q.push_back(held);
            tick_check($sformatf("hold%0d", k));
        end
        hold_e = 1'b0; flush_e = 1'b0;
        drive(tbl[1]);
        check_stall("post_hold", 1'b0);
        exp_q.push_back(expect_of(tbl[1])); tick_check("post_hold");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
